// File: rtl/psc_trigger_pkg.sv
// Shared constants, state encoding and helpers for the PSC trigger frame sequencer.
package psc_trigger_pkg;

   localparam int unsigned PSC_FRAME_LEN = 11;
   localparam logic [7:0]  PSC_SOP_CHAR  = 8'h3C;
   localparam logic [7:0]  PSC_EOP_CHAR  = 8'hBC;
   localparam logic [7:0]  PSC_IDLE_CHAR = 8'hBC;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP
   } seq_state_e;

   // Control characters sit at the SOP address and the two trailing EOP addresses.
   function automatic logic psc_is_k_addr(input logic [3:0] addr, input logic [3:0] last);
      return (addr == 4'd0) || (addr == last) || (addr == (last - 4'd1));
   endfunction

endpackage

// File: rtl/psc_heartbeat_timer.sv
// Idle-cycle counter that flags when a heartbeat frame is due; PERIOD of 0 disables it.
module psc_heartbeat_timer #(
   parameter int unsigned PERIOD = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic count_en,
   input  logic clear,
   output logic expired
);

   localparam int unsigned W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [W-1:0] LAST = (PERIOD == 0) ? '0 : W'(PERIOD - 1);

   logic [W-1:0] count_q, count_d;

   assign expired = (PERIOD != 0) && (count_q == LAST);

   // Count enabled cycles, saturating at expiry so a stalled heartbeat stays due.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_en && (PERIOD != 0) && !expired) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

endmodule

// File: rtl/psc_trigger_data_rom.sv
// Combinational frame content ROM: SOP, trigger marker, zero payload, two EOPs.
module psc_trigger_data_rom
   import psc_trigger_pkg::*;
(
   input  logic [3:0] address,
   input  logic       is_trigger,
   output logic [7:0] data
);

   // Decode address to frame byte; marker bytes are zero for heartbeat frames.
   always_comb begin
      data = 8'h00;
      case (address)
         4'd0:        data = PSC_SOP_CHAR;
         4'd1:        data = is_trigger ? 8'h01 : 8'h00;
         4'd2:        data = is_trigger ? 8'h30 : 8'h00;
         4'd9, 4'd10: data = PSC_EOP_CHAR;
         default:     data = 8'h00;
      endcase
   end

endmodule

// File: rtl/psc_trigger_frame_sequencer.sv
// Walks the trigger data ROM and streams one frame per trigger or heartbeat over valid/ready.
module psc_trigger_frame_sequencer
   import psc_trigger_pkg::*;
#(
   parameter int unsigned FRAME_LEN = PSC_FRAME_LEN,
   parameter int unsigned GAP_LEN   = 4,
   parameter int unsigned HB_PERIOD = 1000,
   parameter logic [7:0]  IDLE_CHAR = PSC_IDLE_CHAR,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             trig_in,
   output logic [3:0]       rom_address,
   output logic             rom_is_trig,
   input  logic [7:0]       rom_data,
   output logic [7:0]       tx_data,
   output logic             tx_k,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic [CNT_W-1:0] trig_count,
   output logic             trig_overrun
);

   localparam logic [3:0]    ADDR_LAST = 4'(FRAME_LEN - 1);
   localparam int unsigned   GW        = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LEN - 1);

   seq_state_e       state_q, state_d;
   logic [3:0]       rom_address_q, rom_address_d;
   logic             rom_is_trig_q, rom_is_trig_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_k_q, tx_k_d;
   logic             tx_valid_q, tx_valid_d;
   logic [CNT_W-1:0] trig_count_q, trig_count_d;
   logic             trig_overrun_q, trig_overrun_d;
   logic             pending_q, pending_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;

   logic load;
   logic start;
   logic hb_expired;

   // The output register may take a new byte when empty or when the current one is accepted.
   assign load = !tx_valid_q || tx_ready;

   psc_heartbeat_timer #(
      .PERIOD (HB_PERIOD)
   ) u_hb_timer (
      .clk      (clk),
      .reset    (reset),
      .count_en (state_q == ST_IDLE),
      .clear    (start),
      .expired  (hb_expired)
   );

   // Next-state, output-register and bookkeeping logic.
   always_comb begin
      state_d        = state_q;
      rom_address_d  = rom_address_q;
      rom_is_trig_d  = rom_is_trig_q;
      tx_data_d      = tx_data_q;
      tx_k_d         = tx_k_q;
      tx_valid_d     = 1'b1;
      trig_count_d   = trig_count_q;
      trig_overrun_d = trig_overrun_q;
      pending_d      = pending_q;
      gap_cnt_d      = gap_cnt_q;
      start          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (load) begin
               tx_data_d = IDLE_CHAR;
               tx_k_d    = 1'b1;
               if (pending_q) begin
                  rom_is_trig_d = 1'b1;
                  pending_d     = 1'b0;
                  start         = 1'b1;
               end else if (hb_expired) begin
                  rom_is_trig_d = 1'b0;
                  start         = 1'b1;
               end
               // Address 0 holds SOP for both frame kinds, so the ROM byte read with the
               // previous is_trig value is already correct for the first byte.
               if (start) begin
                  tx_data_d     = rom_data;
                  tx_k_d        = 1'b1;
                  rom_address_d = 4'd1;
                  state_d       = ST_SEND;
               end
            end
         end
         ST_SEND: begin
            if (load) begin
               tx_data_d = rom_data;
               tx_k_d    = psc_is_k_addr(rom_address_q, ADDR_LAST);
               if (rom_address_q == ADDR_LAST) begin
                  rom_address_d = 4'd0;
                  gap_cnt_d     = '0;
                  state_d       = ST_GAP;
                  if (rom_is_trig_q) trig_count_d = trig_count_q + CNT_W'(1);
               end else begin
                  rom_address_d = rom_address_q + 4'd1;
               end
            end
         end
         ST_GAP: begin
            if (load) begin
               tx_data_d = IDLE_CHAR;
               tx_k_d    = 1'b1;
               if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
               else                       gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A request taken this cycle frees the slot before the new pulse is considered.
      if (trig_in) begin
         if (pending_d) trig_overrun_d = 1'b1;
         else           pending_d      = 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         rom_address_q  <= '0;
         rom_is_trig_q  <= 1'b0;
         tx_data_q      <= IDLE_CHAR;
         tx_k_q         <= 1'b1;
         tx_valid_q     <= 1'b0;
         trig_count_q   <= '0;
         trig_overrun_q <= 1'b0;
         pending_q      <= 1'b0;
         gap_cnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         rom_address_q  <= rom_address_d;
         rom_is_trig_q  <= rom_is_trig_d;
         tx_data_q      <= tx_data_d;
         tx_k_q         <= tx_k_d;
         tx_valid_q     <= tx_valid_d;
         trig_count_q   <= trig_count_d;
         trig_overrun_q <= trig_overrun_d;
         pending_q      <= pending_d;
         gap_cnt_q      <= gap_cnt_d;
      end
   end

   assign rom_address  = rom_address_q;
   assign rom_is_trig  = rom_is_trig_q;
   assign tx_data      = tx_data_q;
   assign tx_k         = tx_k_q;
   assign tx_valid     = tx_valid_q;
   assign busy         = (state_q != ST_IDLE);
   assign trig_count   = trig_count_q;
   assign trig_overrun = trig_overrun_q;

endmodule
